eq_band_sequencer: RTL and testbench
====================================

Name: eq_band_sequencer

Overview:
- Control and data-feed stage directly upstream of the equalizer gain multiply/accumulate stage.
- On each audio sample strobe, steps through all filter bands. For each band it presents the band's 48-bit L/R filter output and that band's 16-bit gain to the MAC.
- Drives the MAC clock-enable and the accumulator load/bypass control, and flags when the summed result is valid.
- Holds the band gain register bank. The bank is written byte-wise from the control interface and is double-buffered so that gains only change on sample boundaries.

Parameters:
- num_of_filters, 4, number of EQ bands (2..16)
- MAC_LATENCY, 2, clocks from the last band presented to the accumulator output holding the final sum
- GAIN_RESET, 16'h4000, reset value of every gain (unity, Q2.14)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- sample_en  in  1  one-cycle strobe, one per audio sample; starts a band sweep
- eq_wr  in  1  gain write strobe
- eq_wr_sel  in  $clog2(num_of_filters)  band index for the gain write
- eq_gain_lsb  in  8  gain low byte
- eq_gain_msb  in  8  gain high byte
- l_data_in  in  48 x num_of_filters  left band filter outputs
- r_data_in  in  48 x num_of_filters  right band filter outputs
- l_band_out  out  48  selected left band sample to the MAC
- r_band_out  out  48  selected right band sample to the MAC
- gain_out  out  16  active gain for the selected band
- mac_ce  out  1  MAC/accumulator clock enable
- accum_bypass  out  1  high on the first band only; accumulator loads instead of adding
- result_valid  out  1  one-cycle pulse; accumulator output holds the finished sum
- busy  out  1  sweep or drain in progress
- sample_overrun  out  1  one-cycle pulse when sample_en arrives while busy

Behaviour:
- Reset (asynchronous, reset_n low):
  - All outputs are 0.
  - Both gain banks (pending and active) are set to GAIN_RESET.
  - FSM goes to IDLE and the band counter to 0.
- Gain write:
  - On eq_wr, pending[eq_wr_sel] <= {eq_gain_msb, eq_gain_lsb}.
  - A write with eq_wr_sel >= num_of_filters is ignored.
- Gain bank copy:
  - The active bank is copied from the pending bank only in the cycle sample_en is accepted in IDLE.
  - A write in that same cycle is included in the copy (write-through: pending and active are both updated).
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: on sample_en, go to RUN with band=0.
  - RUN: one band per clock, band 0..num_of_filters-1. After the last band, go to DRAIN with a counter of MAC_LATENCY.
  - DRAIN: count down. When the count expires, pulse result_valid and return to IDLE.
- Timing (sample_en accepted at cycle T):
  - Band k data and gain are registered onto the outputs at T+1+k.
  - mac_ce is high during T+1..T+num_of_filters.
  - accum_bypass is high at T+1 only.
  - result_valid pulses at T+num_of_filters+MAC_LATENCY.
  - busy is high during T+1 through the result_valid cycle inclusive.
- Idle outputs:
  - While mac_ce is low, l_band_out, r_band_out and gain_out hold their last values.
  - The band counter holds at 0.
- sample_en while busy:
  - The strobe is dropped and sample_overrun pulses in the same cycle.
  - The current sweep is unaffected.
- sample_en in the result_valid cycle: counts as busy, so it is an overrun.
- Band data path: l_data_in / r_data_in are sampled in the cycle the band is selected, with no extra latching. Upstream filters must hold their outputs stable for the whole sweep.
- Reset mid-sweep: everything is cleared immediately and no result_valid is issued.
- No arithmetic inside this block. Widths pass through unchanged.

Decomposition:
- Shared package eq_pkg holds:
  - typedef eq_gain_t (16-bit)
  - typedef eq_sample_t (48-bit)
  - the enum for FSM states
  - constant EQ_UNITY_GAIN = 16'h4000
- One sub-module, eq_gain_bank:
  - pending/active register pair with write port, commit strobe and asynchronous read by band index.
  - Clocked by clk, reset by reset_n.

Test Plan:
- Reset, then a single sample_en with l_data_in = {1,2,3,4}, r_data_in = {5,6,7,8}:
  - l_band_out = 1,2,3,4 at T+1..T+4
  - gain_out = 16'h4000 each cycle
  - accum_bypass only at T+1
  - result_valid at T+6
- Write band 2 gain = 16'h1234 (msb=8'h12, lsb=8'h34) in IDLE, then sample_en:
  - gain_out = 16'h1234 at T+3
  - other bands remain 16'h4000
- Write band 1 gain = 16'h0800 at T+2 mid-sweep:
  - current sweep still shows 16'h4000 for band 1
  - next sweep shows 16'h0800
- sample_en at T+3 and at T+6 (the result_valid cycle):
  - sample_overrun pulses at both cycles
  - exactly one result_valid
  - a fresh sample_en at T+7 starts a normal sweep
- eq_wr with eq_wr_sel = 4 (num_of_filters = 4), value 16'hFFFF:
  - no band gain changes on the following sweep
- Assert reset_n low at T+3 for 1 cycle:
  - all outputs go to 0 asynchronously
  - no result_valid
  - gains return to 16'h4000

Source files
------------

// File: rtl/eq_pkg.sv
// Shared types and constants for the equalizer band sequencer.
package eq_pkg;

  typedef logic [15:0] eq_gain_t;
  typedef logic [47:0] eq_sample_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } eq_state_e;

  localparam eq_gain_t EQ_UNITY_GAIN = 16'h4000;

endpackage

// File: rtl/eq_gain_bank.sv
// Double-buffered band gain registers: byte-assembled writes land in the
// pending bank, and the active bank follows it only on a commit strobe.
// A write in the commit cycle is visible in the copy and on the read port.
module eq_gain_bank
  import eq_pkg::*;
#(
  parameter int          NUM_BANDS  = 4,
  parameter logic [15:0] GAIN_RESET = EQ_UNITY_GAIN,
  localparam int         SW         = $clog2(NUM_BANDS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en_i,
  input  logic [SW-1:0] wr_sel_i,
  input  logic [15:0]   wr_data_i,
  input  logic          commit_i,
  input  logic [SW-1:0] rd_idx_i,
  output logic [15:0]   rd_gain_o
);

  localparam logic [SW:0] NUM_SEL = (SW+1)'(NUM_BANDS);

  eq_gain_t pending_q [NUM_BANDS];
  eq_gain_t pending_d [NUM_BANDS];
  eq_gain_t active_q  [NUM_BANDS];
  eq_gain_t active_d  [NUM_BANDS];
  logic     wr_ok;

  // Out-of-range band selects are silently dropped.
  assign wr_ok = wr_en_i && ({1'b0, wr_sel_i} < NUM_SEL);

  // Pending bank next state: apply this cycle's write.
  always_comb begin
    pending_d = pending_q;
    if (wr_ok) begin
      pending_d[wr_sel_i] = wr_data_i;
    end
  end

  // Active bank next state: take a snapshot of the post-write pending bank on commit.
  always_comb begin
    active_d = active_q;
    if (commit_i) begin
      active_d = pending_d;
    end
  end

  // On commit the reader sees the gains that are about to become active.
  assign rd_gain_o = commit_i ? pending_d[rd_idx_i] : active_q[rd_idx_i];

  // Bank state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_BANDS; i++) begin
        pending_q[i] <= GAIN_RESET;
        active_q[i]  <= GAIN_RESET;
      end
    end else begin
      pending_q <= pending_d;
      active_q  <= active_d;
    end
  end

endmodule

// File: rtl/eq_band_sequencer.sv
// Per-sample band sweep feeding the equalizer gain MAC: presents each band's
// L/R sample with its gain, drives MAC enable / accumulator load, then waits
// out the MAC latency and flags the finished sum.
module eq_band_sequencer
  import eq_pkg::*;
#(
  parameter int          num_of_filters = 4,
  parameter int          MAC_LATENCY    = 2,
  parameter logic [15:0] GAIN_RESET     = EQ_UNITY_GAIN
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               sample_en,
  input  logic                               eq_wr,
  input  logic [$clog2(num_of_filters)-1:0]  eq_wr_sel,
  input  logic [7:0]                         eq_gain_lsb,
  input  logic [7:0]                         eq_gain_msb,
  input  logic [48*num_of_filters-1:0]       l_data_in,
  input  logic [48*num_of_filters-1:0]       r_data_in,
  output logic [47:0]                        l_band_out,
  output logic [47:0]                        r_band_out,
  output logic [15:0]                        gain_out,
  output logic                               mac_ce,
  output logic                               accum_bypass,
  output logic                               result_valid,
  output logic                               busy,
  output logic                               sample_overrun
);

  localparam int                SW         = $clog2(num_of_filters);
  localparam int                CW         = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;
  localparam logic [SW-1:0]     LAST_BAND  = SW'(num_of_filters - 1);
  localparam logic [CW-1:0]     DRAIN_INIT = CW'(MAC_LATENCY - 1);

  eq_state_e     state_q, state_d;
  logic [SW-1:0] band_q, band_d;
  logic [CW-1:0] cnt_q, cnt_d;
  eq_sample_t    l_q, l_d, r_q, r_d;
  eq_gain_t      gain_q, gain_d;
  logic          ce_q, ce_d;
  logic          byp_q, byp_d;
  logic          rv_q, rv_d;
  logic          commit;
  logic          load;
  logic [SW-1:0] sel_idx;
  eq_gain_t      bank_gain;

  eq_sample_t l_bands [num_of_filters];
  eq_sample_t r_bands [num_of_filters];

  for (genvar b = 0; b < num_of_filters; b++) begin : g_unpack
    assign l_bands[b] = l_data_in[b*48 +: 48];
    assign r_bands[b] = r_data_in[b*48 +: 48];
  end

  eq_gain_bank #(
    .NUM_BANDS  (num_of_filters),
    .GAIN_RESET (GAIN_RESET)
  ) u_gain_bank (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en_i   (eq_wr),
    .wr_sel_i  (eq_wr_sel),
    .wr_data_i ({eq_gain_msb, eq_gain_lsb}),
    .commit_i  (commit),
    .rd_idx_i  (sel_idx),
    .rd_gain_o (bank_gain)
  );

  // Sweep FSM: selects the next band to present and schedules the MAC controls.
  always_comb begin
    state_d = state_q;
    band_d  = band_q;
    cnt_d   = cnt_q;
    ce_d    = 1'b0;
    byp_d   = 1'b0;
    rv_d    = 1'b0;
    commit  = 1'b0;
    load    = 1'b0;
    sel_idx = band_q;
    unique case (state_q)
      ST_IDLE: begin
        band_d = '0;
        if (sample_en) begin
          commit  = 1'b1;
          load    = 1'b1;
          sel_idx = '0;
          ce_d    = 1'b1;
          byp_d   = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (band_q == LAST_BAND) begin
          state_d = ST_DRAIN;
          band_d  = '0;
          cnt_d   = DRAIN_INIT;
          rv_d    = (DRAIN_INIT == '0);
        end else begin
          sel_idx = band_q + 1'b1;
          load    = 1'b1;
          ce_d    = 1'b1;
          band_d  = band_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        // result_valid is raised for the DRAIN cycle whose count is zero.
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
          rv_d  = ((cnt_q - 1'b1) == '0);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output data next state: hold while the MAC is not being fed.
  always_comb begin
    l_d    = l_q;
    r_d    = r_q;
    gain_d = gain_q;
    if (load) begin
      l_d    = l_bands[sel_idx];
      r_d    = r_bands[sel_idx];
      gain_d = bank_gain;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      band_q  <= '0;
      cnt_q   <= '0;
      l_q     <= '0;
      r_q     <= '0;
      gain_q  <= '0;
      ce_q    <= 1'b0;
      byp_q   <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      band_q  <= band_d;
      cnt_q   <= cnt_d;
      l_q     <= l_d;
      r_q     <= r_d;
      gain_q  <= gain_d;
      ce_q    <= ce_d;
      byp_q   <= byp_d;
      rv_q    <= rv_d;
    end
  end

  assign l_band_out     = l_q;
  assign r_band_out     = r_q;
  assign gain_out       = gain_q;
  assign mac_ce         = ce_q;
  assign accum_bypass   = byp_q;
  assign result_valid   = rv_q;
  assign busy           = (state_q != ST_IDLE);
  assign sample_overrun = sample_en && busy;

endmodule

// File: tb/tb_eq_band_sequencer.sv
// Directed bench for eq_band_sequencer (4-band main instance plus a 3-band
// instance for the out-of-range gain write).
module tb_eq_band_sequencer;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         sample_en = 1'b0;
  logic         eq_wr = 1'b0;
  logic [1:0]   eq_wr_sel = '0;
  logic [7:0]   eq_gain_lsb = '0;
  logic [7:0]   eq_gain_msb = '0;
  logic [191:0] l_data_in;
  logic [191:0] r_data_in;
  logic [47:0]  l_band_out, r_band_out;
  logic [15:0]  gain_out;
  logic         mac_ce, accum_bypass, result_valid, busy, sample_overrun;

  logic         sample_en3 = 1'b0;
  logic         eq_wr3 = 1'b0;
  logic [1:0]   eq_wr_sel3 = '0;
  logic [143:0] l_data_in3;
  logic [143:0] r_data_in3;
  logic [47:0]  l_band_out3, r_band_out3;
  logic [15:0]  gain_out3;
  logic         mac_ce3, accum_bypass3, result_valid3, busy3, sample_overrun3;

  int vectors = 0;
  int errors  = 0;

  localparam logic [63:0] G_UNITY = {4{16'h4000}};

  always #5 clk = ~clk;

  assign l_data_in  = {48'd4, 48'd3, 48'd2, 48'd1};
  assign r_data_in  = {48'd8, 48'd7, 48'd6, 48'd5};
  assign l_data_in3 = {48'd3, 48'd2, 48'd1};
  assign r_data_in3 = {48'd7, 48'd6, 48'd5};

  eq_band_sequencer #(.num_of_filters(4), .MAC_LATENCY(2), .GAIN_RESET(16'h4000)) dut (
    .clk(clk), .reset_n(reset_n), .sample_en(sample_en),
    .eq_wr(eq_wr), .eq_wr_sel(eq_wr_sel),
    .eq_gain_lsb(eq_gain_lsb), .eq_gain_msb(eq_gain_msb),
    .l_data_in(l_data_in), .r_data_in(r_data_in),
    .l_band_out(l_band_out), .r_band_out(r_band_out), .gain_out(gain_out),
    .mac_ce(mac_ce), .accum_bypass(accum_bypass), .result_valid(result_valid),
    .busy(busy), .sample_overrun(sample_overrun)
  );

  eq_band_sequencer #(.num_of_filters(3), .MAC_LATENCY(2), .GAIN_RESET(16'h4000)) dut3 (
    .clk(clk), .reset_n(reset_n), .sample_en(sample_en3),
    .eq_wr(eq_wr3), .eq_wr_sel(eq_wr_sel3),
    .eq_gain_lsb(eq_gain_lsb), .eq_gain_msb(eq_gain_msb),
    .l_data_in(l_data_in3), .r_data_in(r_data_in3),
    .l_band_out(l_band_out3), .r_band_out(r_band_out3), .gain_out(gain_out3),
    .mac_ce(mac_ce3), .accum_bypass(accum_bypass3), .result_valid(result_valid3),
    .busy(busy3), .sample_overrun(sample_overrun3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_l"},    64'(l_band_out),     64'd0);
    chk({tag, "_r"},    64'(r_band_out),     64'd0);
    chk({tag, "_gain"}, 64'(gain_out),       64'd0);
    chk({tag, "_ce"},   64'(mac_ce),         64'd0);
    chk({tag, "_byp"},  64'(accum_bypass),   64'd0);
    chk({tag, "_rv"},   64'(result_valid),   64'd0);
    chk({tag, "_busy"}, 64'(busy),           64'd0);
    chk({tag, "_ovr"},  64'(sample_overrun), 64'd0);
  endtask

  task automatic wr_gain(input logic [1:0] sel, input logic [15:0] val);
    eq_wr = 1'b1;
    eq_wr_sel = sel;
    eq_gain_msb = val[15:8];
    eq_gain_lsb = val[7:0];
    tick();
    eq_wr = 1'b0;
  endtask

  // Full sweep on the 4-band instance, starting with sample_en in the current
  // cycle T. g holds the expected gain per band (band 0 in bits 15:0).
  // mid_wr writes band 1 = 16'h0800 at T+2; ovr strobes sample_en at T+3 and T+6.
  task automatic sweep(input logic [63:0] g, input bit mid_wr, input bit ovr);
    sample_en = 1'b1;
    #1;
    chk("accept_ovr", 64'(sample_overrun), 64'd0);
    tick();
    sample_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (mid_wr && k == 1) begin
        eq_wr = 1'b1; eq_wr_sel = 2'd1; eq_gain_msb = 8'h08; eq_gain_lsb = 8'h00;
      end
      if (ovr && k == 2) sample_en = 1'b1;
      #1;
      chk($sformatf("l_b%0d", k),    64'(l_band_out),   64'(k + 1));
      chk($sformatf("r_b%0d", k),    64'(r_band_out),   64'(k + 5));
      chk($sformatf("gain_b%0d", k), 64'(gain_out),     64'(g[k*16 +: 16]));
      chk($sformatf("ce_b%0d", k),   64'(mac_ce),       64'd1);
      chk($sformatf("byp_b%0d", k),  64'(accum_bypass), 64'(k == 0));
      chk($sformatf("busy_b%0d", k), 64'(busy),         64'd1);
      chk($sformatf("rv_b%0d", k),   64'(result_valid), 64'd0);
      chk($sformatf("ovr_b%0d", k),  64'(sample_overrun), 64'(ovr && k == 2));
      tick();
      eq_wr = 1'b0;
      sample_en = 1'b0;
    end
    // T+5: drain, outputs hold band 3
    chk("drain_ce",   64'(mac_ce),       64'd0);
    chk("drain_rv",   64'(result_valid), 64'd0);
    chk("drain_busy", 64'(busy),         64'd1);
    chk("drain_l",    64'(l_band_out),   64'd4);
    chk("drain_gain", 64'(gain_out),     64'(g[63:48]));
    tick();
    // T+6: result cycle
    if (ovr) sample_en = 1'b1;
    #1;
    chk("res_rv",   64'(result_valid),   64'd1);
    chk("res_busy", 64'(busy),           64'd1);
    chk("res_ovr",  64'(sample_overrun), 64'(ovr));
    tick();
    sample_en = 1'b0;
    // T+7: idle again
    chk("post_rv",   64'(result_valid), 64'd0);
    chk("post_busy", 64'(busy),         64'd0);
    chk("post_ce",   64'(mac_ce),       64'd0);
  endtask

  initial begin
    // Reset state
    #2 reset_n = 1'b0;
    #1;
    chk_zero("rst");
    tick();
    tick();
    chk_zero("rst_hold");
    reset_n = 1'b1;
    tick();

    // Basic sweep with unity gains
    sweep(G_UNITY, 1'b0, 1'b0);

    // Band 2 gain written in IDLE
    wr_gain(2'd2, 16'h1234);
    sweep({16'h4000, 16'h1234, 16'h4000, 16'h4000}, 1'b0, 1'b0);

    // Mid-sweep write to band 1 only takes effect next sweep
    sweep({16'h4000, 16'h1234, 16'h4000, 16'h4000}, 1'b1, 1'b0);
    sweep({16'h4000, 16'h1234, 16'h0800, 16'h4000}, 1'b0, 1'b0);

    // Overrun at T+3 and in the result cycle, then back-to-back sweep at T+7
    sweep({16'h4000, 16'h1234, 16'h0800, 16'h4000}, 1'b0, 1'b1);
    sweep({16'h4000, 16'h1234, 16'h0800, 16'h4000}, 1'b0, 1'b0);

    // Out-of-range gain write on the 3-band instance is ignored
    eq_wr3 = 1'b1; eq_wr_sel3 = 2'd3; eq_gain_msb = 8'hFF; eq_gain_lsb = 8'hFF;
    tick();
    eq_wr3 = 1'b0;
    sample_en3 = 1'b1;
    tick();
    sample_en3 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("n3_gain_b%0d", k), 64'(gain_out3),     64'h4000);
      chk($sformatf("n3_l_b%0d", k),    64'(l_band_out3),   64'(k + 1));
      chk($sformatf("n3_r_b%0d", k),    64'(r_band_out3),   64'(k + 5));
      chk($sformatf("n3_byp_b%0d", k),  64'(accum_bypass3), 64'(k == 0));
      tick();
    end
    chk("n3_drain_ce", 64'(mac_ce3),       64'd0);
    chk("n3_drain_rv", 64'(result_valid3), 64'd0);
    tick();
    chk("n3_res_rv",   64'(result_valid3),   64'd1);
    chk("n3_res_busy", 64'(busy3),           64'd1);
    chk("n3_res_ovr",  64'(sample_overrun3), 64'd0);
    tick();
    chk("n3_post_busy", 64'(busy3), 64'd0);

    // Reset asserted at T+3 of a sweep on the 4-band instance
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    chk_zero("midrst");
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("midrst_rv_c%0d", c),   64'(result_valid), 64'd0);
      chk($sformatf("midrst_busy_c%0d", c), 64'(busy),         64'd0);
      tick();
    end
    // Gains back at unity after reset
    sweep(G_UNITY, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
